// File: rtl/gpio_ctrl.sv
// Wishbone-classic GPIO controller: DATA/DIR registers, synchronized pad readback,
// and optional edge-triggered interrupts (enabled by defining GPIO_IRQ_EN).
module gpio_ctrl #(
  parameter int NUM_PINS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [2:0]          wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [NUM_PINS-1:0] gpio_dat_o,
  output logic [NUM_PINS-1:0] gpio_dir_o,
  input  logic [NUM_PINS-1:0] gpio_in_i,
  output logic                irq_o
);

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_DIR  = 3'd1;
  localparam logic [2:0] ADR_IN   = 3'd2;

  logic                r_ack;
  logic [31:0]         r_rdat;
  logic [NUM_PINS-1:0] r_data;
  logic [NUM_PINS-1:0] r_dir;
  logic [NUM_PINS-1:0] r_sync1;
  logic [NUM_PINS-1:0] r_sync2;

  logic                w_req;
  logic                w_wr;
  logic [31:0]         w_bit_en;
  logic [NUM_PINS-1:0] w_wr_en;
  logic [NUM_PINS-1:0] w_wr_val;
  logic [NUM_PINS-1:0] w_rd_pins;
  logic [31:0]         w_rd_word;
  logic                w_unused_bits;

  // A new request is refused while the previous ack is still high, so
  // held strobes are acked every other cycle.
  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb_we_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_bit_en[8*gi +: 8] = {8{wb_sel_i[gi]}};
  end

  assign w_wr_en       = w_bit_en[NUM_PINS-1:0];
  assign w_wr_val      = wb_dat_i[NUM_PINS-1:0];
  assign w_unused_bits = ^{wb_dat_i, w_bit_en};

  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old_val,
                                                input logic [NUM_PINS-1:0] en,
                                                input logic [NUM_PINS-1:0] val);
    return (old_val & ~en) | (val & en);
  endfunction

`ifdef GPIO_IRQ_EN
  localparam logic [2:0] ADR_IE   = 3'd4;
  localparam logic [2:0] ADR_IP   = 3'd5;
  localparam logic [2:0] ADR_EDGE = 3'd6;

  logic [NUM_PINS-1:0] r_ie;
  logic [NUM_PINS-1:0] r_ip;
  logic [NUM_PINS-1:0] r_edge;
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] w_ip_set;
  logic [NUM_PINS-1:0] w_ip_clr;

  assign w_ip_set = r_ie & ((r_edge & r_sync2 & ~r_prev) | (~r_edge & ~r_sync2 & r_prev));
  assign w_ip_clr = (w_wr && wb_adr_i == ADR_IP) ? (w_wr_en & w_wr_val) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ie   <= '0;
      r_ip   <= '0;
      r_edge <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= r_sync2;
      if (w_wr && wb_adr_i == ADR_IE)   r_ie   <= merge(r_ie, w_wr_en, w_wr_val);
      if (w_wr && wb_adr_i == ADR_EDGE) r_edge <= merge(r_edge, w_wr_en, w_wr_val);
      // A set on the same edge as a clear wins.
      r_ip <= (r_ip & ~w_ip_clr) | w_ip_set;
    end
  end

  assign irq_o = |(r_ip & r_ie);
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    w_rd_pins = '0;
    case (wb_adr_i)
      ADR_DATA: w_rd_pins = r_data;
      ADR_DIR:  w_rd_pins = r_dir;
      ADR_IN:   w_rd_pins = r_sync2;
`ifdef GPIO_IRQ_EN
      ADR_IE:   w_rd_pins = r_ie;
      ADR_IP:   w_rd_pins = r_ip;
      ADR_EDGE: w_rd_pins = r_edge;
`endif
      default:  w_rd_pins = '0;
    endcase
    w_rd_word                 = '0;
    w_rd_word[NUM_PINS-1:0]   = w_rd_pins;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_rdat  <= '0;
      r_data  <= '0;
      r_dir   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdat  <= (w_req && !wb_we_i) ? w_rd_word : '0;
      r_sync1 <= gpio_in_i;
      r_sync2 <= r_sync1;
      if (w_wr && wb_adr_i == ADR_DATA) r_data <= merge(r_data, w_wr_en, w_wr_val);
      if (w_wr && wb_adr_i == ADR_DIR)  r_dir  <= merge(r_dir, w_wr_en, w_wr_val);
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_rdat;
  assign gpio_dat_o = r_data;
  assign gpio_dir_o = r_dir;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl (32 pins); interrupt checks follow GPIO_IRQ_EN.
module tb_gpio_ctrl;
  localparam int NP = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [2:0]    wb_adr_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [NP-1:0] gpio_dat_o;
  logic [NP-1:0] gpio_dir_o;
  logic [NP-1:0] gpio_in_i = '0;
  logic          irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;
  int lat;

  gpio_ctrl #(.NUM_PINS(NP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .gpio_dat_o(gpio_dat_o),
    .gpio_dir_o(gpio_dir_o), .gpio_in_i(gpio_in_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wb_ack_o && lat < 8);
    if (!wb_ack_o) check("ack_timeout", 32'd0, 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_xfer(1'b1, adr, sel, dat);
  endtask

  task automatic wb_read(input logic [2:0] adr);
    wb_xfer(1'b0, adr, 4'hF, 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (3) tick();
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    check("rst_gpio_dat", gpio_dat_o, 0);
    check("rst_gpio_dir", gpio_dir_o, 0);
    check("rst_irq", irq_o, 0);
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();

    wb_read(3'd0); check("rd_data_rst", rd, 0); check("first_lat", lat, 1);
    wb_read(3'd1); check("rd_dir_rst", rd, 0); check("b2b_lat", lat, 2);
    wb_read(3'd2); check("rd_in_rst", rd, 0);

    wb_write(3'd0, 32'h0000_00A5, 4'hF);
    check("dat_at_ack", gpio_dat_o, 32'hA5);
    tick();
    check("ack_one_cycle", wb_ack_o, 0);
    wb_write(3'd1, 32'h0000_00FF, 4'hF);
    check("dir_at_ack", gpio_dir_o, 32'hFF);
    wb_read(3'd0); check("rd_data", rd, 32'hA5);
    wb_read(3'd1); check("rd_dir", rd, 32'hFF);

    wb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
    wb_read(3'd2); check("in_ro", rd, 0);
    wb_write(3'd3, 32'hFFFF_FFFF, 4'hF);
    wb_read(3'd3); check("rd_0c", rd, 0);
    wb_read(3'd7); check("rd_1c", rd, 0);

    do_reset();
    wb_write(3'd0, 32'h1122_3344, 4'b0010);
    wb_read(3'd0); check("sel_0010", rd, 32'h0000_3300);
    wb_write(3'd0, 32'hAABB_CCDD, 4'b1001);
    wb_read(3'd0); check("sel_1001", rd, 32'hAA00_33DD);

    tick();
    gpio_in_i = 32'h3C;
    wb_read(3'd2); check("in_old", rd, 0);
    wb_read(3'd2); check("in_new", rd, 32'h3C);

`ifdef GPIO_IRQ_EN
    wb_write(3'd4, 32'h1, 4'hF);
    wb_write(3'd6, 32'h1, 4'hF);
    wb_read(3'd4); check("rd_ie", rd, 32'h1);
    wb_read(3'd5); check("ip_none", rd, 0);
    tick();
    gpio_in_i = 32'h3D;
    tick(); check("irq_e1", irq_o, 0);
    tick(); check("irq_e2", irq_o, 0);
    tick(); check("irq_e3", irq_o, 1);
    wb_read(3'd5); check("ip_rise", rd, 32'h1);
    wb_write(3'd5, 32'h1, 4'hF);
    check("irq_w1c", irq_o, 0);
    wb_read(3'd5); check("ip_cleared", rd, 0);

    gpio_in_i = 32'h3C;
    repeat (4) tick();
    check("fall_ignored", irq_o, 0);
    gpio_in_i = 32'h3D;
    tick();
    tick();
    wb_write(3'd5, 32'h1, 4'hF);
    check("set_wins_irq", irq_o, 1);
    wb_read(3'd5); check("set_wins_ip", rd, 32'h1);

    wb_write(3'd4, 32'h0, 4'hF);
    check("ie_mask", irq_o, 0);
    wb_read(3'd5); check("ip_kept", rd, 32'h1);
    gpio_in_i = 32'h3F;
    repeat (4) tick();
    wb_read(3'd5); check("ie_gates_set", rd, 32'h1);

    wb_write(3'd5, 32'hFFFF_FFFF, 4'hF);
    wb_write(3'd6, 32'h0, 4'hF);
    wb_write(3'd4, 32'h1, 4'hF);
    gpio_in_i = 32'h3E;
    repeat (4) tick();
    check("irq_fall", irq_o, 1);
    wb_read(3'd5); check("ip_fall", rd, 32'h1);
`else
    wb_write(3'd4, 32'hFF, 4'hF);
    gpio_in_i = 32'hFF;
    repeat (4) tick();
    gpio_in_i = 32'h00;
    repeat (4) tick();
    check("no_irq", irq_o, 0);
    wb_read(3'd4); check("rd_10", rd, 0);
    wb_read(3'd5); check("rd_14", rd, 0);
    wb_read(3'd6); check("rd_18", rd, 0);
`endif

    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd0;
    rst_i = 1'b0;
    tick(); check("rst_mid_ack", wb_ack_o, 0);
    tick(); check("rst_mid_ack2", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst_i = 1'b1;
    tick();
    check("rst_mid_dat", gpio_dat_o, 0);
    check("rst_mid_dir", gpio_dir_o, 0);
    check("rst_mid_irq", irq_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
